instr_decoder: RTL

Instruction-register and opcode-decode block for the TRISC datapath. It sits between instruction memory and the controller FSM. It captures the fetched instruction word and splits it into opcode and operand. It then presents the one-hot decode lines the controller branches on in its execute-select state, and holds them until the controller acknowledges the execute phase.

---
 rtl/instr_decoder.sv | 117 +++++++++++
 1 files changed

// File: rtl/instr_decoder.sv
// Instruction register and opcode decoder for the TRISC datapath: captures the
// fetched word, decodes its opcode into one-hot lines and holds them until acknowledged.
module instr_decoder #(
  parameter int IW  = 8,
  parameter int OPW = 2
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [IW-1:0]       mem_data,
  input  logic                ir_load,
  input  logic                dec_en,
  input  logic                dec_ack,
  output logic [IW-1:0]       ir,
  output logic [IW-OPW-1:0]   operand,
  output logic                dec_f,
  output logic                dec_g,
  output logic                dec_h,
  output logic                dec_valid,
  output logic                illegal,
  output logic                busy,
  output logic [15:0]         instr_count
);

  localparam int AW = IW - OPW;

  typedef enum logic [1:0] {IDLE, LOADED, DECODED} state_t;

  state_t            state, state_n;
  logic [IW-1:0]     ir_n;
  logic [AW-1:0]     operand_n;
  logic              dec_f_n, dec_g_n, dec_h_n, dec_valid_n;
  logic              illegal_n, busy_n;
  logic [15:0]       count_n;
  logic [OPW-1:0]    opcode;

  assign opcode = ir[IW-1:AW];

  // A load always wins over a decode, but an acknowledge in the same cycle is still counted.
  always_comb begin
    state_n     = state;
    ir_n        = ir;
    operand_n   = operand;
    dec_f_n     = dec_f;
    dec_g_n     = dec_g;
    dec_h_n     = dec_h;
    dec_valid_n = dec_valid;
    illegal_n   = illegal;
    count_n     = instr_count;

    if (ir_load) begin
      if (state == DECODED && dec_ack)
        count_n = instr_count + 16'd1;
      ir_n        = mem_data;
      operand_n   = mem_data[AW-1:0];
      dec_f_n     = 1'b0;
      dec_g_n     = 1'b0;
      dec_h_n     = 1'b0;
      dec_valid_n = 1'b0;
      state_n     = LOADED;
    end else begin
      case (state)
        LOADED: begin
          if (dec_en) begin
            dec_f_n     = (int'(opcode) == 0);
            dec_g_n     = (int'(opcode) == 1);
            dec_h_n     = (int'(opcode) == 2);
            dec_valid_n = 1'b1;
            if (int'(opcode) >= 3)
              illegal_n = 1'b1;
            state_n     = DECODED;
          end
        end
        DECODED: begin
          if (dec_ack) begin
            dec_f_n     = 1'b0;
            dec_g_n     = 1'b0;
            dec_h_n     = 1'b0;
            dec_valid_n = 1'b0;
            count_n     = instr_count + 16'd1;
            state_n     = IDLE;
          end
        end
        default: begin
        end
      endcase
    end

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= IDLE;
      ir          <= '0;
      operand     <= '0;
      dec_f       <= 1'b0;
      dec_g       <= 1'b0;
      dec_h       <= 1'b0;
      dec_valid   <= 1'b0;
      illegal     <= 1'b0;
      busy        <= 1'b0;
      instr_count <= '0;
    end else begin
      state       <= state_n;
      ir          <= ir_n;
      operand     <= operand_n;
      dec_f       <= dec_f_n;
      dec_g       <= dec_g_n;
      dec_h       <= dec_h_n;
      dec_valid   <= dec_valid_n;
      illegal     <= illegal_n;
      busy        <= busy_n;
      instr_count <= count_n;
    end
  end

endmodule
